// File: rtl/dac_spi_writer_if.sv
// Sample-in / SPI-out bundle of the DAC writer: upstream sample strobe plus serial pins and status.
interface dac_spi_writer_if #(
  parameter int fxp_size = 16
);
  logic                valid;
  logic [fxp_size-1:0] i_sample;
  logic                o_sclk;
  logic                o_cs_n;
  logic                o_mosi;
  logic                o_busy;
  logic                o_overrun;
  logic                o_clip;

  modport master (
    output valid, i_sample,
    input  o_sclk, o_cs_n, o_mosi, o_busy, o_overrun, o_clip
  );

  modport slave (
    input  valid, i_sample,
    output o_sclk, o_cs_n, o_mosi, o_busy, o_overrun, o_clip
  );
endinterface

// File: rtl/dac_spi_writer.sv
// Serialises signed samples to an MCP4921-style SPI DAC with a one-entry pending slot.
// Optional macro DAC_SATURATE_EN: clamp out-of-range samples and pulse o_clip instead of wrapping.
module dac_spi_writer #(
  parameter int         fxp_size       = 16,
  parameter int         bits_per_level = 12,
  parameter int         clk_div        = 4,
  parameter logic [3:0] config_bits    = 4'b0011
) (
  input logic              clk,
  input logic              rst,
  dac_spi_writer_if.slave  bus
);

  localparam int FRAME_W = 4 + bits_per_level;
  localparam int HALVES  = 2 * FRAME_W;
  localparam int HW      = $clog2(HALVES);
  localparam int IW      = $clog2(FRAME_W);
  localparam int CW      = (clk_div > 1) ? $clog2(clk_div) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t               state_q, state_d;
  logic [HW-1:0]        h_q, h_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [FRAME_W-1:0]   pend_q, pend_d;
  logic                 pvld_q, pvld_d;
  logic                 ovr_q, ovr_d;
  logic                 sclk_q, sclk_d;
  logic                 cs_n_q, cs_n_d;
  logic                 mosi_q, mosi_d;
  logic                 busy_q, busy_d;

  logic [bits_per_level-1:0] lvl;
  logic [FRAME_W-1:0]        conv_frame;
  logic                      half_end;

`ifdef DAC_SATURATE_EN
  localparam logic signed [fxp_size-1:0] SMAX = fxp_size'((1 << (bits_per_level - 1)) - 1);
  localparam logic signed [fxp_size-1:0] SMIN = ~SMAX;

  logic clip_now;
  logic clip_q;

  always_comb begin
    lvl      = bus.i_sample[bits_per_level-1:0];
    clip_now = 1'b0;
    if ($signed(bus.i_sample) > SMAX) begin
      lvl      = SMAX[bits_per_level-1:0];
      clip_now = 1'b1;
    end else if ($signed(bus.i_sample) < SMIN) begin
      lvl      = SMIN[bits_per_level-1:0];
      clip_now = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) clip_q <= 1'b0;
    else     clip_q <= bus.valid & clip_now;
  end

  assign bus.o_clip = clip_q;
`else
  // Wrap-around: only the low level bits matter, the rest are deliberately ignored.
  logic unused_hi;
  assign unused_hi  = ^bus.i_sample[fxp_size-1:bits_per_level];
  assign lvl        = bus.i_sample[bits_per_level-1:0];
  assign bus.o_clip = 1'b0;
`endif

  // Offset-binary: flip the sign bit of the two's-complement level.
  assign conv_frame = {config_bits, ~lvl[bits_per_level-1], lvl[bits_per_level-2:0]};
  assign half_end   = (cnt_q == CW'(clk_div - 1));

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    pend_d  = pend_q;
    pvld_d  = pvld_q;
    ovr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.valid) begin
          state_d = SHIFT;
          h_d     = '0;
          cnt_d   = '0;
          frame_d = conv_frame;
        end
      end
      SHIFT: begin
        cnt_d = half_end ? '0 : cnt_q + 1'b1;
        if (half_end) begin
          if (h_q == HW'(HALVES - 1)) state_d = GAP;
          else                        h_d     = h_q + 1'b1;
        end
        if (bus.valid) begin
          pend_d = conv_frame;
          pvld_d = 1'b1;
          ovr_d  = pvld_q;
        end
      end
      GAP: begin
        cnt_d = half_end ? '0 : cnt_q + 1'b1;
        if (half_end) begin
          // A fresh sample wins over the pending one; the pending slot empties either way.
          h_d    = '0;
          pvld_d = 1'b0;
          if (bus.valid) begin
            state_d = SHIFT;
            frame_d = conv_frame;
            ovr_d   = pvld_q;
          end else if (pvld_q) begin
            state_d = SHIFT;
            frame_d = pend_q;
          end else begin
            state_d = IDLE;
          end
        end else if (bus.valid) begin
          pend_d = conv_frame;
          pvld_d = 1'b1;
          ovr_d  = pvld_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pins are registered from next state so they change cleanly on the clk edge.
    sclk_d = (state_d == SHIFT) && h_d[0];
    cs_n_d = (state_d != SHIFT);
    mosi_d = (state_d == SHIFT) ? frame_d[IW'(FRAME_W - 1) - IW'(h_d >> 1)] : 1'b0;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      h_q     <= '0;
      cnt_q   <= '0;
      frame_q <= '0;
      pend_q  <= '0;
      pvld_q  <= 1'b0;
      ovr_q   <= 1'b0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      pend_q  <= pend_d;
      pvld_q  <= pvld_d;
      ovr_q   <= ovr_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_sclk    = sclk_q;
  assign bus.o_cs_n    = cs_n_q;
  assign bus.o_mosi    = mosi_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_overrun = ovr_q;

endmodule
